// File: rtl/regfile_alu_pkg.sv
// Shared types and constants for the sequenced register-file + ALU engine.
// Operation codes, FSM states and flag bit positions live here.
package regfile_alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd8,
        ALU_SRA  = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RR   = 2'd1,
        EX   = 2'd2,
        WB   = 2'd3
    } state_e;

    localparam int FR_ZF = 3;
    localparam int FR_CF = 2;
    localparam int FR_OF = 1;
    localparam int FR_SF = 0;

endpackage

// File: rtl/alu_unit.sv
// Combinational ALU: result plus ZF/CF/OF/SF flags for one operand pair.
// CF/OF are meaningful only for ADD and SUB; every other op clears them.
module alu_unit
    import regfile_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] result,
    output logic [3:0]      flags
);

    localparam int SHW = $clog2(XLEN);
    localparam int MSB = XLEN - 1;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;
    logic [SHW-1:0]  shamt;
    logic            cf;
    logic            of;

    // The extra top bit of diff is the borrow, i.e. a < b unsigned.
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        cf     = 1'b0;
        of     = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[XLEN-1:0];
                cf     = sum[XLEN];
                of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = diff[XLEN-1:0];
                cf     = diff[XLEN];
                of     = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

    always_comb begin
        flags        = '0;
        flags[FR_ZF] = (result == '0);
        flags[FR_CF] = cf;
        flags[FR_OF] = of;
        flags[FR_SF] = result[MSB];
    end

endmodule

// File: rtl/regfile_alu_seq.sv
// Register file + ALU sequenced by a 4-state FSM: IDLE -> RR -> EX -> WB.
// Handshake: an op is accepted on the rising edge where op_valid && op_ready.
module regfile_alu_seq
    import regfile_alu_pkg::*;
#(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [AW-1:0]   r_addr_a,
    input  logic [AW-1:0]   r_addr_b,
    input  logic [AW-1:0]   w_addr,
    input  logic [3:0]      alu_op,
    input  logic            reg_write,
    input  logic            ld_en,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    output logic [XLEN-1:0] f,
    output logic [3:0]      fr,
    output logic            done,
    output state_e          dbg_state
);

    state_e            state;
    logic [XLEN-1:0]   regs [NREG];
    logic [AW-1:0]     a_q;
    logic [AW-1:0]     b_q;
    logic [AW-1:0]     w_q;
    logic [3:0]        op_q;
    logic              we_q;
    logic [XLEN-1:0]   opnd_a;
    logic [XLEN-1:0]   opnd_b;
    logic [XLEN-1:0]   alu_res;
    logic [3:0]        alu_flags;

    alu_unit #(.XLEN(XLEN)) u_alu (
        .a      (opnd_a),
        .b      (opnd_b),
        .op     (op_q),
        .result (alu_res),
        .flags  (alu_flags)
    );

    assign dbg_state = state;

    // regs[0] is never written, so it reads as zero everywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_ready <= 1'b1;
            done     <= 1'b0;
            f        <= '0;
            fr       <= '0;
            a_q      <= '0;
            b_q      <= '0;
            w_q      <= '0;
            op_q     <= '0;
            we_q     <= 1'b0;
            opnd_a   <= '0;
            opnd_b   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (ld_en && (ld_addr != '0)) begin
                        regs[ld_addr] <= ld_data;
                    end
                    if (op_valid) begin
                        a_q      <= r_addr_a;
                        b_q      <= r_addr_b;
                        w_q      <= w_addr;
                        op_q     <= alu_op;
                        we_q     <= reg_write;
                        op_ready <= 1'b0;
                        state    <= RR;
                    end
                end
                RR: begin
                    opnd_a <= regs[a_q];
                    opnd_b <= regs[b_q];
                    state  <= EX;
                end
                EX: begin
                    f     <= alu_res;
                    fr    <= alu_flags;
                    done  <= 1'b1;
                    state <= WB;
                end
                WB: begin
                    if (we_q && (w_q != '0)) begin
                        regs[w_q] <= f;
                    end
                    done     <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    done     <= 1'b0;
                    op_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench for regfile_alu_seq: vector table of ops with optional
// same-cycle loads, plus hand sequences for back-pressure and async reset.
module tb_regfile_alu_seq;
    import regfile_alu_pkg::*;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk;
    logic            rst_n;
    logic            op_valid;
    logic            op_ready;
    logic [AW-1:0]   r_addr_a;
    logic [AW-1:0]   r_addr_b;
    logic [AW-1:0]   w_addr;
    logic [3:0]      alu_op;
    logic            reg_write;
    logic            ld_en;
    logic [AW-1:0]   ld_addr;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] f;
    logic [3:0]      fr;
    logic            done;
    state_e          dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            ld_en;
        logic [AW-1:0]   ld_addr;
        logic [XLEN-1:0] ld_data;
        logic [AW-1:0]   a;
        logic [AW-1:0]   b;
        logic [AW-1:0]   w;
        logic [3:0]      op;
        logic            we;
        logic [XLEN-1:0] exp_f;
        logic [3:0]      exp_fr;
    } vec_t;

    vec_t vq[$];

    regfile_alu_seq #(.XLEN(XLEN), .NREG(NREG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .r_addr_a  (r_addr_a),
        .r_addr_b  (r_addr_b),
        .w_addr    (w_addr),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .f         (f),
        .fr        (fr),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic le, input int la, input logic [XLEN-1:0] ld,
                           input int a, input int b, input int w, input int op,
                           input logic we, input logic [XLEN-1:0] ef, input logic [3:0] efr);
        vec_t v;
        v.ld_en = le; v.ld_addr = AW'(la); v.ld_data = ld;
        v.a = AW'(a); v.b = AW'(b); v.w = AW'(w); v.op = 4'(op); v.we = we;
        v.exp_f = ef; v.exp_fr = efr;
        vq.push_back(v);
    endtask

    // Called at a negedge while IDLE; returns at a negedge while IDLE.
    task automatic do_load(input int addr, input logic [XLEN-1:0] data);
        ld_en = 1'b1; ld_addr = AW'(addr); ld_data = data;
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input vec_t v);
        int lat;
        lat = 0;
        ld_en = v.ld_en; ld_addr = v.ld_addr; ld_data = v.ld_data;
        r_addr_a = v.a; r_addr_b = v.b; w_addr = v.w;
        alu_op = v.op; reg_write = v.we; op_valid = 1'b1;
        chk({tag, ".ready"}, op_ready, 1);
        @(posedge clk); #1;
        op_valid = 1'b0; ld_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".lat"}, lat, 3);
        chk({tag, ".f"}, f, v.exp_f);
        chk({tag, ".fr"}, fr, v.exp_fr);
        @(negedge clk);
        chk({tag, ".done_low"}, done, 0);
    endtask

    initial begin
        vec_t v;
        int   ready_cnt;

        rst_n = 1'b0; op_valid = 1'b0; r_addr_a = '0; r_addr_b = '0; w_addr = '0;
        alu_op = '0; reg_write = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) @(negedge clk);
        chk("rst.f", f, 0);
        chk("rst.fr", fr, 0);
        chk("rst.done", done, 0);
        chk("rst.ready", op_ready, 1);
        chk("rst.state", dbg_state, IDLE);
        rst_n = 1'b1;
        @(negedge clk);

        do_load(1, 32'd5);
        do_load(2, 32'd7);

        //      ld  la  ld_data       a  b  w  op  we  exp_f         exp_fr
        add_vec(0,  0,  32'h0,        1, 2, 3, 0,  1,  32'd12,       4'b0000);
        add_vec(0,  0,  32'h0,        3, 0, 0, 0,  0,  32'd12,       4'b0000);
        add_vec(0,  0,  32'h0,        0, 1, 2, 0,  1,  32'd5,        4'b0000);
        add_vec(0,  0,  32'h0,        1, 2, 3, 0,  1,  32'd10,       4'b0000);
        add_vec(1,  4,  32'h1,        0, 0, 0, 0,  0,  32'd0,        4'b1000);
        add_vec(1,  1,  32'h7FFFFFFF, 1, 4, 0, 0,  0,  32'h80000000, 4'b0011);
        add_vec(0,  0,  32'h0,        4, 1, 0, 8,  0,  32'h80000002, 4'b0101);
        add_vec(1,  5,  32'hFFFFFFFF, 5, 4, 0, 0,  1,  32'h0,        4'b1100);
        add_vec(0,  0,  32'h0,        4, 4, 0, 0,  1,  32'd2,        4'b0000);
        add_vec(1,  0,  32'hDEAD,     0, 4, 0, 0,  0,  32'd1,        4'b0000);
        add_vec(1,  7,  32'h4,        4, 7, 0, 1,  0,  32'h10,       4'b0000);
        add_vec(1,  6,  32'h80000000, 6, 7, 0, 13, 0,  32'hF8000000, 4'b0001);
        add_vec(0,  0,  32'h0,        6, 7, 0, 5,  0,  32'h08000000, 4'b0000);
        add_vec(0,  0,  32'h0,        6, 4, 0, 2,  0,  32'd1,        4'b0000);
        add_vec(0,  0,  32'h0,        6, 4, 0, 3,  0,  32'd0,        4'b1000);
        add_vec(0,  0,  32'h0,        5, 6, 0, 4,  0,  32'h7FFFFFFF, 4'b0000);
        add_vec(0,  0,  32'h0,        6, 4, 0, 6,  0,  32'h80000001, 4'b0001);
        add_vec(0,  0,  32'h0,        5, 7, 0, 7,  0,  32'h4,        4'b0000);
        add_vec(0,  0,  32'h0,        5, 5, 0, 9,  0,  32'h0,        4'b1000);
        add_vec(0,  0,  32'h0,        7, 7, 0, 8,  0,  32'h0,        4'b1000);
        add_vec(0,  0,  32'h0,        6, 6, 0, 0,  0,  32'h0,        4'b1110);
        add_vec(1,  8,  32'h24,       6, 8, 0, 5,  0,  32'h08000000, 4'b0000);
        add_vec(0,  0,  32'h0,        5, 5, 0, 15, 0,  32'h0,        4'b1000);

        foreach (vq[i]) begin
            run_op($sformatf("vec%0d", i), vq[i]);
        end

        // op_valid held high: one accept every 4 cycles, load during EX dropped
        r_addr_a = 5'd0; r_addr_b = 5'd4; w_addr = 5'd0; alu_op = 4'd0;
        reg_write = 1'b0; op_valid = 1'b1;
        ready_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("hold.ready%0d", k), op_ready, ((k % 4) == 0) ? 1 : 0);
            if (op_ready) ready_cnt++;
            if (k == 2) begin
                ld_en = 1'b1; ld_addr = 5'd9; ld_data = 32'h55;
            end
            if (k == 3) ld_en = 1'b0;
            @(negedge clk);
        end
        op_valid = 1'b0;
        chk("hold.accepts", ready_cnt, 3);
        chk("hold.f", f, 1);
        @(negedge clk);
        v = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd0, 4'd0, 1'b0, 32'h0, 4'b1000};
        run_op("ld_in_ex", v);
        v = '{1'b1, 5'd10, 32'h33, 5'd10, 5'd0, 5'd0, 4'd0, 1'b0, 32'h33, 4'b0000};
        run_op("pre_rst", v);

        // Asynchronous reset while the FSM sits in EX
        r_addr_a = 5'd10; r_addr_b = 5'd0; w_addr = 5'd11; alu_op = 4'd0;
        reg_write = 1'b1; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(posedge clk); #2;
        chk("mid.state", dbg_state, EX);
        rst_n = 1'b0;
        #1;
        chk("arst.f", f, 0);
        chk("arst.fr", fr, 0);
        chk("arst.done", done, 0);
        chk("arst.ready", op_ready, 1);
        chk("arst.state", dbg_state, IDLE);
        repeat (3) @(negedge clk);
        chk("arst.done_hold", done, 0);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1'b0, 5'd0, 32'h0, 5'd10, 5'd11, 5'd0, 4'd0, 1'b0, 32'h0, 4'b1000};
        run_op("arst.regs10_11", v);
        v = '{1'b0, 5'd0, 32'h0, 5'd1, 5'd5, 5'd0, 4'd6, 1'b0, 32'h0, 4'b1000};
        run_op("arst.regs1_5", v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_alu_seq.md
Name: regfile_alu_seq

Overview:
Single-clock, multi-cycle register-file + ALU engine that sequences register read, ALU execute and write-back internally. It replaces the three externally strobed phase clocks (RR, F, WB) with one clock, an FSM and a valid/ready operation handshake. Width and register count are parametrised, and the block adds an initialisation load port. It sits between the instruction-decode stage and the rest of the teaching-CPU datapath.

Parameters:
XLEN, 32, data width of registers, ALU and F.
NREG, 32, number of registers; power of two, at least 2.
AW, $clog2(NREG), register address width (derived; not overridden).

Ports:
clk  in  1  sole clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
op_valid  in  1  operation request.
op_ready  out  1  high only in IDLE; an op is accepted on the edge where op_valid && op_ready.
r_addr_a  in  AW  source A address, sampled at accept.
r_addr_b  in  AW  source B address, sampled at accept.
w_addr  in  AW  destination address, sampled at accept.
alu_op  in  4  operation code, sampled at accept.
reg_write  in  1  write-back enable, sampled at accept.
ld_en  in  1  direct register load (initialisation/debug).
ld_addr  in  AW  load address.
ld_data  in  XLEN  load data.
f  out  XLEN  registered ALU result.
fr  out  4  registered flags: fr[3]=ZF, fr[2]=CF, fr[1]=OF, fr[0]=SF.
done  out  1  high for exactly one cycle, while in WB.

Behaviour:
- Reset (asynchronous, any state, including mid-operation): state=IDLE, all registers=0, f=0, fr=0, done=0, op_ready=1. Any in-flight op is discarded.
- FSM: IDLE -> RR on accept. RR -> EX unconditionally. EX -> WB unconditionally. WB -> IDLE unconditionally. No back-to-back accept; throughput is 1 op per 4 cycles.
- IDLE: op_ready=1. Latch addresses, alu_op and reg_write on accept.
- RR: latch operands A=reg[a], B=reg[b].
- EX: register f and fr from the ALU result.
- WB: done=1. At the end-of-cycle edge, write reg[w_addr]=f if reg_write and w_addr!=0.
- Latency: accept edge at T. f/fr are valid after edge T+2. The write takes effect at edge T+3.
- Hazards: the write completes before the next op's RR, so a following op that reads w_addr sees the new value. No forwarding logic is needed.
- Register 0 always reads 0. Writes and loads to address 0 are ignored.
- Load port: honoured only in IDLE. Writes reg[ld_addr]=ld_data at the edge. ld_en outside IDLE is ignored.
- Load and op accept in the same cycle: both take effect. The op's RR reads the loaded value.
- f and fr hold their value between operations; they change only in EX.
- ALU ops (the result is truncated to XLEN):
  - 0 ADD; 8 SUB (A-B).
  - 1 SLL; 5 SRL; 13 SRA. Shift amount = B[$clog2(XLEN)-1:0].
  - 2 SLT (signed); 3 SLTU. Result is 1 or 0.
  - 4 XOR; 6 OR; 7 AND.
  - Any other code: result 0.
- Flags:
  - ZF = (result==0).
  - SF = result[XLEN-1].
  - CF: for ADD, the carry-out. For SUB, the borrow, i.e. 1 when A<B unsigned.
  - OF: two's-complement overflow, for ADD/SUB only.
  - CF and OF are 0 for all other ops.

Decomposition:
- Shared package regfile_alu_pkg:
  - alu_op_e enum with the codes above.
  - state_e {IDLE, RR, EX, WB}.
  - Flag index constants FR_ZF=3, FR_CF=2, FR_OF=1, FR_SF=0.
- One combinational sub-module, alu_unit. It is parametrised by XLEN: inputs A, B, op; outputs result and flags.
- The register array and FSM stay in the top.

Test Plan:
1. Reset then ld reg1=5, reg2=7. Op a=1, b=2, w=3, ADD, reg_write=1 -> f=12, fr=0000. done is high exactly 3 cycles after the accept edge, and a read of reg3 then returns 12.
2. Op a=0, b=1, w=2, ADD, reg_write=1 after reg1=5 -> f=5. Next op a=1, b=2, w=3, ADD -> f=10, which confirms the write-back is visible with no hazard.
3. reg1=0x7FFFFFFF, reg2=1, ADD -> f=0x80000000, OF=1, SF=1, CF=0. SUB of reg2-reg1 -> CF=1.
4. reg1=0xFFFFFFFF, ADD with reg2=1 -> f=0, ZF=1, CF=1. Then reg_write=1 with w=0 -> reg0 still reads 0.
5. op_valid held high continuously -> op_ready low in RR/EX/WB, exactly one accept per 4 cycles. ld_en asserted in EX is ignored.
6. rst_n asserted low asynchronously mid-EX -> f=0, fr=0, done=0 immediately, state IDLE, all registers 0, and no write occurs.
